// File: rtl/shake256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shake256_pkg
// Description : Shared types and constants for the SHAKE256 absorb datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package shake256_pkg;

    typedef logic [63:0] lane_t;
    typedef lane_t [4:0][4:0] keccak_state_t;  // indexed [x][y]

    localparam int         RATE_LANES_DEF = 17;
    localparam logic [7:0] DS_SHAKE       = 8'h1F;
    localparam logic [7:0] PAD_END        = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PERM = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } absorb_state_e;

endpackage
`default_nettype wire

// File: rtl/shake256_pad_lane.sv
`default_nettype none
// ============================================================================
// Module      : shake256_pad_lane
// Description : Builds the XOR word for one rate lane: masked message bytes,
//               domain byte at position in_bytes, and the final 0x80 pad bit.
// Revision    : 1.0 - initial release
// ============================================================================
module shake256_pad_lane
    import shake256_pkg::*;
#(
    parameter logic [7:0] DS_BYTE = DS_SHAKE
) (
    input  lane_t      in_data,
    input  logic [3:0] in_bytes,
    input  logic       last,
    input  logic       ds_en,
    input  logic       end_en,
    output lane_t      xor_word
);

    lane_t w_mask;
    lane_t w_ds;
    lane_t w_end;

    always_comb begin
        w_mask = '1;
        w_ds   = '0;
        // A count of 8 (or more) means the lane is full: no masking, no DS here.
        if (last && (in_bytes < 4'd8)) begin
            for (int b = 0; b < 8; b++) begin
                if (4'(b) >= in_bytes) begin
                    w_mask[b*8 +: 8] = 8'h00;
                end
            end
        end
        if (ds_en && (in_bytes < 4'd8)) begin
            w_ds = {56'h0, DS_BYTE} << {in_bytes[2:0], 3'b000};
        end
        w_end    = end_en ? {PAD_END, 56'h0} : '0;
        xor_word = (in_data & w_mask) ^ w_ds ^ w_end;
    end

endmodule
`default_nettype wire

// File: rtl/shake256_absorb.sv
`default_nettype none
// ============================================================================
// Module      : shake256_absorb
// Description : SHAKE256 absorb/pad front end; hands each rate block to an
//               external KECCAK-f engine. Optional SHAKE256_ABSORB_BLKCNT_EN
//               adds a saturating permutation counter on blk_count.
// Revision    : 1.0 - initial release
// ============================================================================
module shake256_absorb
    import shake256_pkg::*;
#(
    parameter int         RATE_LANES = RATE_LANES_DEF,
    parameter logic [7:0] DS_BYTE    = DS_SHAKE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic [3:0]    in_bytes,
    input  logic          in_last,
    output logic          perm_start,
    output keccak_state_t perm_state_out,
    input  keccak_state_t perm_state_in,
    input  logic          perm_done,
    output logic          state_valid,
    input  logic          state_ack
`ifdef SHAKE256_ABSORB_BLKCNT_EN
    ,
    output logic [15:0]   blk_count
`endif
);

    localparam int CNT_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(RATE_LANES - 1);

    absorb_state_e    r_fsm_q, w_fsm_d;
    keccak_state_t    r_state_q, w_state_d, w_absorbed;
    logic [CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic             r_pad_pending_q, w_pad_pending_d;
    logic             r_final_q, w_final_d;
    logic             r_perm_start_q, w_perm_start_d;
    logic             r_state_valid_q, w_state_valid_d;
    logic             r_in_ready_q, w_in_ready_d;

    logic w_accept, w_full, w_at_end, w_overflow, w_final_now, w_ds_next, w_pad_now;

    assign in_ready       = r_in_ready_q & ~rst;
    assign perm_start     = r_perm_start_q;
    assign state_valid    = r_state_valid_q;
    assign perm_state_out = r_state_q;

    assign w_accept    = in_valid & in_ready;
    assign w_full      = (in_bytes >= 4'd8);
    assign w_at_end    = (r_cnt_q == c_LAST);
    // A full final lane in the last rate slot leaves no room for padding.
    assign w_overflow  = w_accept & in_last & w_full & w_at_end;
    assign w_final_now = w_accept & in_last & ~w_overflow;
    assign w_ds_next   = w_accept & in_last & w_full & ~w_at_end;
    assign w_pad_now   = (r_fsm_q == ST_PAD);

    for (genvar gi = 0; gi < RATE_LANES; gi++) begin : g_lane
        localparam int               c_X     = gi % 5;
        localparam int               c_Y     = gi / 5;
        localparam logic [CNT_W-1:0] c_IDX   = CNT_W'(gi);
        localparam bit               c_FIRST = (gi == 0);
        localparam bit               c_END   = (gi == RATE_LANES - 1);

        logic  w_hit;
        logic  w_ds_here;
        lane_t w_xor_word;

        assign w_hit     = w_accept && (r_cnt_q == c_IDX);
        assign w_ds_here = (w_ds_next && ((r_cnt_q + 1'b1) == c_IDX)) || (w_pad_now && c_FIRST);

        shake256_pad_lane #(
            .DS_BYTE (DS_BYTE)
        ) u_pad_lane (
            .in_data  (w_hit ? in_data : 64'h0),
            .in_bytes (w_hit ? in_bytes : 4'd0),
            .last     (w_hit ? in_last : w_ds_here),
            .ds_en    (w_hit ? in_last : w_ds_here),
            .end_en   (c_END && (w_final_now || w_pad_now)),
            .xor_word (w_xor_word)
        );

        assign w_absorbed[c_X][c_Y] = r_state_q[c_X][c_Y] ^ w_xor_word;
    end

    for (genvar gj = RATE_LANES; gj < 25; gj++) begin : g_cap
        assign w_absorbed[gj % 5][gj / 5] = r_state_q[gj % 5][gj / 5];
    end

    always_comb begin
        w_fsm_d         = r_fsm_q;
        w_state_d       = w_absorbed;
        w_cnt_d         = r_cnt_q;
        w_pad_pending_d = r_pad_pending_q;
        w_final_d       = r_final_q;
        w_perm_start_d  = 1'b0;
        case (r_fsm_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (in_last) begin
                        w_cnt_d         = '0;
                        w_fsm_d         = ST_PERM;
                        w_perm_start_d  = 1'b1;
                        w_pad_pending_d = w_overflow;
                        w_final_d       = ~w_overflow;
                    end else if (w_at_end) begin
                        w_cnt_d        = '0;
                        w_fsm_d        = ST_PERM;
                        w_perm_start_d = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                end
            end
            ST_PERM: begin
                if (perm_done) begin
                    w_state_d = perm_state_in;
                    if (r_pad_pending_q) begin
                        w_fsm_d         = ST_PAD;
                        w_pad_pending_d = 1'b0;
                    end else if (r_final_q) begin
                        w_fsm_d = ST_DONE;
                    end else begin
                        w_fsm_d = ST_IDLE;
                    end
                end
            end
            ST_PAD: begin
                w_fsm_d        = ST_PERM;
                w_perm_start_d = 1'b1;
                w_final_d      = 1'b1;
            end
            ST_DONE: begin
                if (state_ack) begin
                    w_state_d = '0;
                    w_cnt_d   = '0;
                    w_final_d = 1'b0;
                    w_fsm_d   = ST_IDLE;
                end
            end
            default: w_fsm_d = ST_IDLE;
        endcase
        w_in_ready_d    = (w_fsm_d == ST_IDLE);
        w_state_valid_d = (w_fsm_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm_q         <= ST_IDLE;
            r_state_q       <= '0;
            r_cnt_q         <= '0;
            r_pad_pending_q <= 1'b0;
            r_final_q       <= 1'b0;
            r_perm_start_q  <= 1'b0;
            r_state_valid_q <= 1'b0;
            r_in_ready_q    <= 1'b1;
        end else begin
            r_fsm_q         <= w_fsm_d;
            r_state_q       <= w_state_d;
            r_cnt_q         <= w_cnt_d;
            r_pad_pending_q <= w_pad_pending_d;
            r_final_q       <= w_final_d;
            r_perm_start_q  <= w_perm_start_d;
            r_state_valid_q <= w_state_valid_d;
            r_in_ready_q    <= w_in_ready_d;
        end
    end

`ifdef SHAKE256_ABSORB_BLKCNT_EN
    logic [15:0] r_blk_count_q, w_blk_count_d;

    always_comb begin
        w_blk_count_d = r_blk_count_q;
        if (state_ack) begin
            w_blk_count_d = '0;
        end else if (r_perm_start_q && (r_blk_count_q != 16'hFFFF)) begin
            w_blk_count_d = r_blk_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_count_q <= '0;
        end else begin
            r_blk_count_q <= w_blk_count_d;
        end
    end

    assign blk_count = r_blk_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shake256_absorb.sv
`default_nettype none
// ============================================================================
// Module      : tb_shake256_absorb
// Description : Self-checking bench for shake256_absorb with a byte-level
//               pad10*1 reference model and a stand-in permutation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shake256_absorb;
    import shake256_pkg::*;

    localparam int c_RATE       = 17;
    localparam int c_RATE_BYTES = c_RATE * 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic [3:0]    in_bytes;
    logic          in_last;
    logic          perm_start;
    keccak_state_t perm_state_out;
    keccak_state_t perm_state_in;
    logic          perm_done;
    logic          state_valid;
    logic          state_ack;
`ifdef SHAKE256_ABSORB_BLKCNT_EN
    logic [15:0]   blk_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    keccak_state_t exp_q[$];
    keccak_state_t exp_final;
    logic [7:0]    msg[$];

    always #5 clk = ~clk;

    shake256_absorb #(
        .RATE_LANES (c_RATE),
        .DS_BYTE    (8'h1F)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_bytes       (in_bytes),
        .in_last        (in_last),
        .perm_start     (perm_start),
        .perm_state_out (perm_state_out),
        .perm_state_in  (perm_state_in),
        .perm_done      (perm_done),
        .state_valid    (state_valid),
        .state_ack      (state_ack)
`ifdef SHAKE256_ABSORB_BLKCNT_EN
        ,
        .blk_count      (blk_count)
`endif
    );

    // Stand-in permutation: lane rotate plus a per-lane constant.
    function automatic keccak_state_t fperm(input keccak_state_t s);
        keccak_state_t r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[x][y] = {s[x][y][56:0], s[x][y][63:57]} ^ {8'hA5, 48'h0, 8'(x * 5 + y + 1)};
        return r;
    endfunction

    // Byte-stream model: message || DS || 0* with 0x80 on the last rate byte.
    function automatic int build_model();
        int            len;
        int            total;
        int            nblk;
        logic [7:0]    p[];
        keccak_state_t s;
        len   = msg.size();
        total = (len / c_RATE_BYTES + 1) * c_RATE_BYTES;
        nblk  = total / c_RATE_BYTES;
        p     = new[total];
        for (int i = 0; i < total; i++) p[i] = (i < len) ? msg[i] : 8'h00;
        p[len]       ^= 8'h1F;
        p[total - 1] ^= 8'h80;
        s = '0;
        exp_q.delete();
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < c_RATE; i++)
                for (int j = 0; j < 8; j++)
                    s[i % 5][i / 5][j*8 +: 8] ^= p[b * c_RATE_BYTES + i * 8 + j];
            exp_q.push_back(s);
            s = fperm(s);
        end
        exp_final = s;
        return nblk;
    endfunction

    task automatic fill_random(input int nbytes);
        msg.delete();
        for (int i = 0; i < nbytes; i++) msg.push_back(8'($urandom));
    endtask

    task automatic run_msg(input string name, input int n_last, input int perm_delay,
                           input int ack_delay, input bit junk);
        int            n_lanes;
        int            sent;
        int            pend;
        int            cnt;
        int            ack_cnt;
        int            blk;
        int            nblk;
        bit            done;
        bit            seen_valid;
        bit            bad;
        keccak_state_t resp;
        keccak_state_t expv;
        n_lanes    = (msg.size() - n_last) / 8 + 1;
        nblk       = build_model();
        sent       = 0; pend = 0; cnt = 0; ack_cnt = 0; blk = 0;
        done       = 1'b0;
        seen_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            in_last   = 1'b0;
            perm_done = 1'b0;
            state_ack = 1'b0;
            if (perm_start) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra_perm_start blk%0d got 1 want 0", name, blk);
                end else begin
                    expv = exp_q.pop_front();
                    if (perm_state_out !== expv) begin
                        n_err++;
                        bad = 1'b0;
                        for (int x = 0; x < 5; x++)
                            for (int y = 0; y < 5; y++)
                                if (!bad && perm_state_out[x][y] !== expv[x][y]) begin
                                    bad = 1'b1;
                                    $display("FAIL %s perm_state blk%0d lane[%0d][%0d] got %h want %h",
                                             name, blk, x, y, perm_state_out[x][y], expv[x][y]);
                                end
                    end
                end
                blk++;
                resp = fperm(perm_state_out);
                pend = 1;
                cnt  = perm_delay;
            end
            if (pend != 0) begin
                n_cmp++;
                if (in_ready !== 1'b0 || state_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s busy_flags got rdy=%b sv=%b want 0 0", name, in_ready, state_valid);
                end
                if (junk) begin
                    in_valid = 1'b1;
                    in_data  = {$urandom, $urandom};
                    in_bytes = 4'd0;
                    in_last  = 1'b1;
                end
                if (cnt == 0) begin
                    perm_state_in = resp;
                    perm_done     = 1'b1;
                    pend          = 0;
                end else begin
                    cnt--;
                end
            end else if (state_valid || seen_valid) begin
                n_cmp++;
                if (state_valid !== 1'b1 || in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s done_hold got sv=%b rdy=%b want 1 0", name, state_valid, in_ready);
                end
                if (!seen_valid) begin
                    n_cmp++;
                    if (perm_state_out !== exp_final) begin
                        n_err++;
                        $display("FAIL %s final_state lane00 got %h want %h", name,
                                 perm_state_out[0][0], exp_final[0][0]);
                    end
`ifdef SHAKE256_ABSORB_BLKCNT_EN
                    n_cmp++;
                    if (blk_count !== 16'(nblk)) begin
                        n_err++;
                        $display("FAIL %s blk_count got %0d want %0d", name, blk_count, nblk);
                    end
`endif
                end
                seen_valid = 1'b1;
                if (ack_cnt == ack_delay) begin
                    state_ack = 1'b1;
                    done      = 1'b1;
                end else begin
                    ack_cnt++;
                end
            end else if (in_ready && sent < n_lanes) begin
                for (int j = 0; j < 8; j++) begin
                    if (sent * 8 + j < msg.size() && (sent < n_lanes - 1 || j < n_last))
                        in_data[j*8 +: 8] = msg[sent * 8 + j];
                    else
                        in_data[j*8 +: 8] = 8'($urandom);
                end
                in_valid = 1'b1;
                in_last  = (sent == n_lanes - 1);
                in_bytes = (sent == n_lanes - 1) ? 4'(n_last) : 4'($urandom_range(0, 15));
                sent++;
            end
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s timeout got no state_valid/ack want completion", name);
        end
        @(negedge clk);
        state_ack = 1'b0;
        n_cmp++;
        if (state_valid !== 1'b0 || in_ready !== 1'b1 || perm_state_out !== '0) begin
            n_err++;
            $display("FAIL %s post_ack got sv=%b rdy=%b lane00=%h want 0 1 0", name,
                     state_valid, in_ready, perm_state_out[0][0]);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s perm_count got %0d want %0d", name, blk, nblk);
        end
`ifdef SHAKE256_ABSORB_BLKCNT_EN
        n_cmp++;
        if (blk_count !== 16'd0) begin
            n_err++;
            $display("FAIL %s blk_count_clear got %0d want 0", name, blk_count);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || perm_start !== 1'b0 || state_valid !== 1'b0 || perm_state_out !== '0) begin
            n_err++;
            $display("FAIL reset_values got rdy=%b ps=%b sv=%b lane00=%h want 0 0 0 0",
                     in_ready, perm_start, state_valid, perm_state_out[0][0]);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_empty();
        msg.delete();
        run_msg("empty", 0, 0, 0, 1'b0);
    endtask

    task automatic test_abc();
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        run_msg("abc", 3, 2, 1, 1'b0);
    endtask

    task automatic test_lengths();
        for (int n = 0; n <= 8; n++) begin
            fill_random(8 + n);
            run_msg($sformatf("len_n%0d", n), n, n % 4, 0, 1'b0);
        end
    endtask

    task automatic test_end_byte();
        fill_random(16 * 8 + 7);
        run_msg("end_byte_9f", 7, 1, 0, 1'b0);
    endtask

    task automatic test_overflow();
        fill_random(17 * 8);
        run_msg("overflow", 8, 3, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill_random(37 * 8 + 4);
        run_msg("multi_block", 4, 0, 0, 1'b0);
    endtask

    task automatic test_slow_handshake();
        fill_random(3 * 8 + 2);
        run_msg("slow_done_ack", 2, 40, 5, 1'b1);
    endtask

    task automatic test_idle_perm_done();
        keccak_state_t e;
        logic [63:0]   d;
        d = {$urandom, $urandom};
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = 1'b0; in_bytes = 4'd3;
        @(negedge clk);
        in_valid      = 1'b0;
        perm_done     = 1'b1;
        perm_state_in = {25{64'hDEAD_BEEF_0BAD_F00D}};
        @(negedge clk);
        perm_done = 1'b0;
        e = '0;
        e[0][0] = d;
        n_cmp++;
        if (perm_state_out !== e || perm_start !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_perm_done lane00 got %h want %h (ps=%b rdy=%b)",
                     perm_state_out[0][0], d, perm_start, in_ready);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_in_reset got %b want 0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (perm_state_out !== '0) begin
            n_err++;
            $display("FAIL reset_clears_state lane00 got %h want 0", perm_state_out[0][0]);
        end
    endtask

    task automatic test_rst_mid_perm();
        for (int k = 0; k < c_RATE; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_last = 1'b0; in_bytes = 4'd8;
            in_data  = {$urandom, $urandom};
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (perm_start !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_perm_start got %b want 1", perm_start);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || perm_state_out !== '0 || state_valid !== 1'b0 || perm_start !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_perm_clear got rdy=%b lane00=%h sv=%b ps=%b want 0 0 0 0",
                     in_ready, perm_state_out[0][0], state_valid, perm_start);
        end
        rst           = 1'b0;
        perm_done     = 1'b1;
        perm_state_in = {25{64'h0123_4567_89AB_CDEF}};
        @(negedge clk);
        perm_done = 1'b0;
        n_cmp++;
        if (perm_state_out !== '0 || in_ready !== 1'b1 || state_valid !== 1'b0) begin
            n_err++;
            $display("FAIL late_perm_done got lane00=%h rdy=%b sv=%b want 0 1 0",
                     perm_state_out[0][0], in_ready, state_valid);
        end
`ifdef SHAKE256_ABSORB_BLKCNT_EN
        n_cmp++;
        if (blk_count !== 16'd0) begin
            n_err++;
            $display("FAIL blk_count_rst got %0d want 0", blk_count);
        end
`endif
        msg.delete();
        run_msg("after_rst", 0, 1, 0, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        in_bytes      = '0;
        in_last       = 1'b0;
        perm_state_in = '0;
        perm_done     = 1'b0;
        state_ack     = 1'b0;
        test_reset();
        test_empty();
        test_abc();
        test_lengths();
        test_end_byte();
        test_overflow();
        test_back_to_back();
        test_slow_handshake();
        test_idle_perm_done();
        test_rst_mid_perm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shake256_absorb.md
SHAKE256_ABSORB -- requirements
Module: shake256_absorb

Interface
REQ-001 SHALL have parameter RATE_LANES, default 17, meaning rate in 64-bit lanes (1088 bits).
REQ-002 SHALL have parameter DS_BYTE, default 8'h1F, meaning the SHAKE domain/pad-start byte.
REQ-003 SHALL have clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have in_valid  input  1, in_ready  output  1: message lane handshake; transfer when both are high.
REQ-006 SHALL have in_data  input  64  message lane, little-endian bytes, and in_bytes  input  4  valid byte count (0..8), sampled only with in_last.
REQ-007 SHALL have in_last  input  1  marking the final lane of the message.
REQ-008 SHALL have perm_start  output  1  one-cycle pulse requesting a KECCAK_f permutation of perm_state_out.
REQ-009 SHALL have perm_state_out  output  keccak_state_t (5x5x64, [x][y])  current state, and perm_state_in  input  keccak_state_t  permuted state.
REQ-010 SHALL have perm_done  input  1  one-cycle pulse; perm_state_in is valid in that cycle.
REQ-011 SHALL have state_valid  output  1  absorbed state ready for squeeze, and state_ack  input  1  consumer release.

Function
REQ-012 Lane i SHALL map to x = i mod 5, y = i div 5; a lane counter 0..RATE_LANES-1 selects the lane.
REQ-013 FSM states SHALL be IDLE, PERM, PAD, DONE; in_ready = 1 only in IDLE.
REQ-014 Accepted non-last lane: state[lane] ^= in_data; counter +1; at RATE_LANES-1 the counter wraps to 0 and the FSM enters PERM.
REQ-015 Accepted last lane with n = in_bytes < 8: bytes 0..n-1 XOR data, byte n XOR DS_BYTE, upper bytes zero.
REQ-016 Last lane with n = 8: full lane XOR; DS_BYTE goes to byte 0 of the next lane in the same cycle.
REQ-017 Every final block: byte 7 of lane RATE_LANES-1 ^= 0x80 in the same cycle; coincident with DS the byte becomes 0x9F.
REQ-018 Overflow case (last lane = lane RATE_LANES-1 with n = 8): data XOR only; PERM with pad_pending set, then PAD (one cycle: lane0 byte0 ^= DS_BYTE, lane RATE_LANES-1 byte7 ^= 0x80), then PERM.
REQ-019 perm_start SHALL pulse in the first PERM cycle only; the FSM waits for perm_done with no timeout.
REQ-020 On perm_done: state <= perm_state_in; next state is IDLE (more input), PAD (pad_pending), or DONE (final).
REQ-021 perm_done outside PERM SHALL be ignored; in_valid outside IDLE is not accepted.
REQ-022 DONE: state_valid = 1 and held until state_ack; on ack the state and counter clear to zero and the FSM returns to IDLE.
REQ-023 perm_state_out SHALL be the state register at all times, with no combinational path from in_data.

Reset
REQ-024 rst SHALL clear the state to zero, the counter to 0, pad_pending to 0, and the FSM to IDLE; in_ready is 0 while rst is high.
REQ-025 rst mid-PERM SHALL abandon the operation; a later perm_done is ignored by REQ-021.
REQ-026 Reset values: perm_start 0, state_valid 0, perm_state_out zero.

Configuration
REQ-027 Macro SHAKE256_ABSORB_BLKCNT_EN defined: adds output blk_count  16  counting perm_start pulses; saturates at 16'hFFFF; zero on rst and on state_ack.
REQ-028 Without SHAKE256_ABSORB_BLKCNT_EN: no blk_count port or logic; all other behaviour is identical.

Structure
REQ-029 Package shake256_pkg SHALL hold lane_t (64b), keccak_state_t, RATE_LANES_DEF = 17, DS_SHAKE = 8'h1F, PAD_END = 8'h80, and the FSM enum.
REQ-030 Sub-module shake256_pad_lane (combinational: in_data, in_bytes, last, ds_en, end_en -> 64-bit XOR word) SHALL produce all lane XOR values.

Verification
REQ-031 Empty message (in_last, in_bytes = 0, lane 0): at perm_start [0][0] = 0x1F, [1][3] = 0x8000000000000000, all other lanes 0.
REQ-032 One 3-byte message 0x636261 ("abc"): at perm_start [0][0] = 0x1F636261, [1][3] = 0x8000000000000000.
REQ-033 Seventeen full lanes, last = lane 16: two perm_start pulses; before the second pulse state = P1 ^ {[0][0] ^= 0x1F, [1][3] ^= 0x80<<56}.
REQ-034 Sixteen full lanes then last with in_bytes = 7: one perm_start; lane 16 byte7 = 0x9F.
REQ-035 perm_done delayed 40 cycles, then state_ack held off 5 cycles: in_ready stays 0 throughout and state_valid holds until ack; rst asserted mid-PERM returns to IDLE with zero state.
